// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: synchronises and debounces the board switches, then drives the
// LEDs in direct, toggle, chase or count mode. Everything is registered.

// One debounce lane: the stable output follows the synchronised input only
// after it has differed for CYCLES consecutive clocks.
module sw_led_ctrl_db #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sync,
  output logic o_stable
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;

  // Count differing cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (i_sync == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(CYCLES - 1)) begin
      r_stable <= i_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;
endmodule

module sw_led_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CHASE_DIV       = 25000000
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic [WIDTH-1:0] SW,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] LED,
  output logic [WIDTH-1:0] SW_STABLE
);
  localparam int PS_W = (CHASE_DIV > 1) ? $clog2(CHASE_DIV) : 1;

  typedef enum logic [1:0] {
    M_DIRECT = 2'b00,
    M_TOGGLE = 2'b01,
    M_CHASE  = 2'b10,
    M_COUNT  = 2'b11
  } mode_t;

  logic [WIDTH-1:0] r_sw_s1, r_sw_s2;
  logic [1:0]       r_mode_s1, r_mode_s2;
  mode_t            r_mode_q;
  logic [WIDTH-1:0] r_sw_stable_d;
  logic [WIDTH-1:0] r_tog;
  logic [PS_W-1:0]  r_presc;
  logic [WIDTH-1:0] r_pos;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_led;

  logic [WIDTH-1:0] w_sw_stable;
  logic [WIDTH-1:0] w_rise;
  mode_t            w_mode_sync;
  logic             w_mode_chg;
  logic             w_run;
  logic             w_step;

  // Two-flop synchronisers for the asynchronous switch and mode pins.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_mode_s1 <= '0;
      r_mode_s2 <= '0;
    end else begin
      r_sw_s1   <= SW;
      r_sw_s2   <= r_sw_s1;
      r_mode_s1 <= MODE;
      r_mode_s2 <= r_mode_s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    sw_led_ctrl_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (CLK100MHZ),
      .rst_n    (CPU_RESETN),
      .i_sync   (r_sw_s2[i]),
      .o_stable (w_sw_stable[i])
    );
  end

  assign SW_STABLE   = w_sw_stable;
  assign w_mode_sync = mode_t'(r_mode_s2);
  assign w_mode_chg  = (w_mode_sync != r_mode_q);
  assign w_run       = (r_mode_q == M_CHASE) || (r_mode_q == M_COUNT);
  assign w_step      = w_run && (r_presc == PS_W'(CHASE_DIV - 1));
  // Only rising edges of the debounced switch matter for toggle mode.
  assign w_rise      = w_sw_stable & ~r_sw_stable_d;

  // Registered mode and edge-detect history.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_mode_q      <= M_DIRECT;
      r_sw_stable_d <= '0;
    end else begin
      r_mode_q      <= w_mode_sync;
      r_sw_stable_d <= w_sw_stable;
    end
  end

  // Toggle state survives mode changes; rises outside toggle mode are dropped.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)
      r_tog <= '0;
    else if (r_mode_q == M_TOGGLE)
      r_tog <= r_tog ^ w_rise;
  end

  // Prescaler, chase position and counter; a mode change restarts all three.
  // SW_STABLE[0] selects chase direction and pauses the counter.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_presc <= '0;
      r_pos   <= {{(WIDTH-1){1'b0}}, 1'b1};
      r_cnt   <= '0;
    end else if (w_mode_chg) begin
      r_presc <= '0;
      r_pos   <= {{(WIDTH-1){1'b0}}, 1'b1};
      r_cnt   <= '0;
    end else if (w_run) begin
      r_presc <= w_step ? '0 : r_presc + 1'b1;
      if (w_step && r_mode_q == M_CHASE)
        r_pos <= w_sw_stable[0] ? {r_pos[0], r_pos[WIDTH-1:1]}
                                : {r_pos[WIDTH-2:0], r_pos[WIDTH-1]};
      if (w_step && r_mode_q == M_COUNT && !w_sw_stable[0])
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // LED output register, selected by the registered mode.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_led <= '0;
    end else begin
      case (r_mode_q)
        M_DIRECT: r_led <= w_sw_stable;
        M_TOGGLE: r_led <= r_tog ^ w_rise;
        M_CHASE:  r_led <= r_pos;
        default:  r_led <= r_cnt;
      endcase
    end
  end

  assign LED = r_led;
endmodule

// File: tb/tb_sw_led_ctrl.sv
// tb_sw_led_ctrl: directed scenario tasks plus a randomized run checked
// against a behavioural reference model.
module tb_sw_led_ctrl;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [1:0] mode = 2'b00;
  logic [7:0] led, sws;

  int n_checks = 0;
  int n_fail   = 0;

  sw_led_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CHASE_DIV(CD)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .SW         (sw),
    .MODE       (mode),
    .LED        (led),
    .SW_STABLE  (sws)
  );

  always #5 clk = ~clk;

  // Reference model: pipeline of the last two input samples, per-bit run
  // length of disagreement, chase as an integer index, count as an integer.
  logic [7:0] m_sw1, m_sw2, m_stab, m_stab_d, m_tog, m_led, m_cnt;
  logic [1:0] m_md1, m_md2, m_mq;
  int         m_run [8];
  int         m_idx, m_presc;

  always @(posedge clk or negedge rst_n) begin : ref_model
    logic [7:0] rise, n_stab, n_led;
    int         n_run [8];
    if (!rst_n) begin
      m_sw1 = 0; m_sw2 = 0; m_stab = 0; m_stab_d = 0; m_tog = 0; m_led = 0;
      m_cnt = 0; m_md1 = 0; m_md2 = 0; m_mq = 0; m_idx = 0; m_presc = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else begin
      rise = m_stab & ~m_stab_d;
      case (m_mq)
        2'd0:    n_led = m_stab;
        2'd1:    n_led = m_tog ^ rise;
        2'd2:    n_led = 8'(1 << m_idx);
        default: n_led = m_cnt;
      endcase
      n_stab = m_stab;
      for (int i = 0; i < 8; i++) begin
        if (m_sw2[i] !== m_stab[i]) begin
          n_run[i] = m_run[i] + 1;
          if (n_run[i] == D) begin
            n_stab[i] = m_sw2[i];
            n_run[i]  = 0;
          end
        end else begin
          n_run[i] = 0;
        end
      end
      if (m_mq == 2'd1) m_tog = m_tog ^ rise;
      if (m_md2 != m_mq) begin
        m_presc = 0; m_idx = 0; m_cnt = 0;
      end else if (m_mq >= 2'd2) begin
        if (m_presc == CD - 1) begin
          m_presc = 0;
          if (m_mq == 2'd2)
            m_idx = m_stab[0] ? (m_idx + W - 1) % W : (m_idx + 1) % W;
          else if (!m_stab[0])
            m_cnt = 8'((int'(m_cnt) + 1) % 256);
        end else begin
          m_presc = m_presc + 1;
        end
      end
      m_stab_d = m_stab;
      m_stab   = n_stab;
      m_run    = n_run;
      m_led    = n_led;
      m_mq     = m_md2;
      m_md2    = m_md1;
      m_md1    = mode;
      m_sw2    = m_sw1;
      m_sw1    = sw;
    end
  end

  task automatic do_reset(input logic [7:0] s, input logic [1:0] m);
    @(negedge clk);
    rst_n = 1'b0; sw = s; mode = m;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    sw = 8'hFF; mode = 2'b00;
    repeat (10) @(negedge clk);
    n_checks++;
    if (led !== 8'hFF) begin n_fail++; $display("FAIL reset_pre led=%h exp=ff", led); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (led !== 8'h00) begin n_fail++; $display("FAIL reset_async led=%h exp=00", led); end
    n_checks++;
    if (sws !== 8'h00) begin n_fail++; $display("FAIL reset_async sw_stable=%h exp=00", sws); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 5) begin
        n_checks++;
        if (sws !== 8'h00) begin n_fail++; $display("FAIL reset_e5 sw_stable=%h exp=00", sws); end
      end
      if (e == 6) begin
        n_checks++;
        if (sws !== 8'hFF) begin n_fail++; $display("FAIL reset_e6 sw_stable=%h exp=ff", sws); end
        n_checks++;
        if (led !== 8'h00) begin n_fail++; $display("FAIL reset_e6 led=%h exp=00", led); end
      end
      if (e == 7) begin
        n_checks++;
        if (led !== 8'hFF) begin n_fail++; $display("FAIL reset_e7 led=%h exp=ff", led); end
      end
    end
  endtask

  task automatic test_bounce;
    do_reset(8'h00, 2'b00);
    for (int k = 0; k < 10; k++) begin
      sw[3] = ~sw[3];
      repeat (2) begin
        @(negedge clk);
        n_checks++;
        if (led !== 8'h00) begin n_fail++; $display("FAIL bounce_hold led=%h exp=00", led); end
      end
    end
    sw[3] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 6) begin
        n_checks++;
        if (led[3] !== 1'b0) begin n_fail++; $display("FAIL bounce_e6 led3=%b exp=0", led[3]); end
      end
      if (e == 7) begin
        n_checks++;
        if (led !== 8'h08) begin n_fail++; $display("FAIL bounce_e7 led=%h exp=08", led); end
      end
    end
  endtask

  task automatic test_toggle;
    logic [7:0] pat [5];
    logic [7:0] exp [5];
    pat = '{8'h04, 8'h00, 8'h04, 8'h00, 8'h05};
    exp = '{8'h04, 8'h04, 8'h00, 8'h00, 8'h05};
    do_reset(8'h00, 2'b01);
    for (int k = 0; k < 5; k++) begin
      sw = pat[k];
      repeat (10) @(negedge clk);
      n_checks++;
      if (led !== exp[k]) begin n_fail++; $display("FAIL toggle_%0d led=%h exp=%h", k, led, exp[k]); end
    end
  endtask

  task automatic test_chase;
    int b;
    logic [7:0] exp;
    do_reset(8'h00, 2'b10);
    b = 0;
    while (led !== 8'h01 && b < 20) begin @(negedge clk); b++; end
    n_checks++;
    if (led !== 8'h01) begin n_fail++; $display("FAIL chase_start led=%h exp=01", led); end
    for (int k = 1; k <= 19; k++) begin
      repeat (3) @(negedge clk);
      if (k <= 16)      exp = 8'(1 << (k % 8));
      else if (k == 17) exp = 8'h80;
      else if (k == 18) exp = 8'h40;
      else              exp = 8'h20;
      n_checks++;
      if (led !== exp) begin n_fail++; $display("FAIL chase_step%0d led=%h exp=%h", k, led, exp); end
      if (k == 14) sw = 8'h01;
    end
  endtask

  task automatic test_count;
    int b;
    do_reset(8'h00, 2'b11);
    b = 0;
    while (led !== 8'h01 && b < 20) begin @(negedge clk); b++; end
    n_checks++;
    if (led !== 8'h01) begin n_fail++; $display("FAIL count_start led=%h exp=01", led); end
    for (int k = 2; k <= 256; k++) begin
      repeat (3) @(negedge clk);
      n_checks++;
      if (led !== 8'(k % 256)) begin n_fail++; $display("FAIL count_step%0d led=%h exp=%h", k, led, 8'(k % 256)); end
    end
    sw = 8'h01;
    repeat (30) @(negedge clk);
    n_checks++;
    if (led !== 8'h02) begin n_fail++; $display("FAIL count_pause led=%h exp=02", led); end
    mode = 2'b10;
    repeat (12) @(negedge clk);
    mode = 2'b11;
    repeat (12) @(negedge clk);
    n_checks++;
    if (led !== 8'h00) begin n_fail++; $display("FAIL count_restart led=%h exp=00", led); end
  endtask

  task automatic test_midop_reset;
    int b;
    do_reset(8'h00, 2'b10);
    b = 0;
    while (led !== 8'h01 && b < 20) begin @(negedge clk); b++; end
    repeat (12) @(negedge clk);
    n_checks++;
    if (led !== 8'h10) begin n_fail++; $display("FAIL midop_pre led=%h exp=10", led); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (led !== 8'h00) begin n_fail++; $display("FAIL midop_async led=%h exp=00", led); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b = 0;
    while (led !== 8'h01 && b < 20) begin @(negedge clk); b++; end
    n_checks++;
    if (led !== 8'h01) begin n_fail++; $display("FAIL midop_restart led=%h exp=01", led); end
    for (int k = 1; k <= 2; k++) begin
      repeat (3) @(negedge clk);
      n_checks++;
      if (led !== 8'(1 << k)) begin n_fail++; $display("FAIL midop_step%0d led=%h exp=%h", k, led, 8'(1 << k)); end
    end
  endtask

  task automatic test_random;
    int cyc, hold, r;
    do_reset(8'h00, 2'b00);
    cyc = 0;
    while (cyc < 3000) begin
      hold = $urandom_range(1, 12);
      r    = $urandom_range(0, 99);
      if (r < 3) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else if (r < 25) begin
        mode = 2'($urandom);
      end else begin
        sw = 8'($urandom);
      end
      repeat (hold) begin
        @(negedge clk);
        cyc++;
        n_checks++;
        if (led !== m_led) begin n_fail++; $display("FAIL rand_led cyc=%0d led=%h exp=%h", cyc, led, m_led); end
        n_checks++;
        if (sws !== m_stab) begin n_fail++; $display("FAIL rand_sw_stable cyc=%0d got=%h exp=%h", cyc, sws, m_stab); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sw = 8'h00; mode = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_bounce();
    test_toggle();
    test_chase();
    test_count();
    test_midop_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
